// File: rtl/tour_cmd_seq.sv
// Command-source sequencer for the command processor. In IDLE it passes
// UART commands straight through; after start_tour it replays the stored
// knight's tour, issuing a vertical leg and then a horizontal leg (with
// fanfare) per move, and waits for the processor's response after each leg.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  output logic [7:0]  resp,
  output logic        in_tour
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] V_RESP = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] H_RESP = 3'd4;

  localparam logic [3:0] OpMove    = 4'h4;
  localparam logic [3:0] OpFanfare = 4'h5;

  localparam logic [7:0] HeadN = 8'h00;
  localparam logic [7:0] HeadW = 8'h3F;
  localparam logic [7:0] HeadS = 8'h7F;
  localparam logic [7:0] HeadE = 8'hBF;

  localparam logic [7:0] RespDone = 8'hA5;
  localparam logic [7:0] RespBusy = 8'h5A;

  localparam logic [4:0] LastIdx = 5'(NUM_MOVES - 1);

  logic [2:0] state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;

  logic [7:0] vhead, hhead;
  logic [1:0] vsq, hsq;
  logic       last_move;

  assign last_move = (mv_indx_q == LastIdx);

  // Decode the knight move into its two legs; lowest set bit wins, zero acts as bit0.
  always_comb begin
    vhead = HeadN;
    vsq   = 2'd2;
    hhead = HeadW;
    hsq   = 2'd1;
    casez (move)
      8'b???????1: begin vhead = HeadN; vsq = 2'd2; hhead = HeadW; hsq = 2'd1; end
      8'b??????10: begin vhead = HeadN; vsq = 2'd2; hhead = HeadE; hsq = 2'd1; end
      8'b?????100: begin vhead = HeadN; vsq = 2'd1; hhead = HeadW; hsq = 2'd2; end
      8'b????1000: begin vhead = HeadS; vsq = 2'd1; hhead = HeadW; hsq = 2'd2; end
      8'b???10000: begin vhead = HeadS; vsq = 2'd2; hhead = HeadW; hsq = 2'd1; end
      8'b??100000: begin vhead = HeadS; vsq = 2'd2; hhead = HeadE; hsq = 2'd1; end
      8'b?1000000: begin vhead = HeadS; vsq = 2'd1; hhead = HeadE; hsq = 2'd2; end
      8'b10000000: begin vhead = HeadN; vsq = 2'd1; hhead = HeadE; hsq = 2'd2; end
      default:     begin vhead = HeadN; vsq = 2'd2; hhead = HeadW; hsq = 2'd1; end
    endcase
  end

  // Next-state and move-index logic; responses advance the tour, accepts end a leg.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = 5'd0;
        end
      end
      VERT:   if (clr_cmd_rdy) state_d = V_RESP;
      V_RESP: if (send_resp)   state_d = HORZ;
      HORZ:   if (clr_cmd_rdy) state_d = H_RESP;
      H_RESP: begin
        if (send_resp) begin
          if (last_move) begin
            state_d   = IDLE;
            mv_indx_d = 5'd0;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mv_indx_d = 5'd0;
      end
    endcase
  end

  // State and move index registers; reset aborts any tour in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Output mux: UART pass-through in IDLE, tour legs otherwise. The UART ack
  // is held low during a tour so a pending host command waits for IDLE.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = RespDone;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RespDone;
      end
      VERT, V_RESP: begin
        cmd              = {OpMove, vhead, 2'b00, vsq};
        cmd_rdy          = (state_q == VERT);
        clr_cmd_rdy_UART = 1'b0;
        resp             = RespBusy;
      end
      HORZ, H_RESP: begin
        cmd              = {OpFanfare, hhead, 2'b00, hsq};
        cmd_rdy          = (state_q == HORZ);
        clr_cmd_rdy_UART = 1'b0;
        resp             = (state_q == H_RESP && last_move) ? RespDone : RespBusy;
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RespDone;
      end
    endcase
  end

  assign mv_indx = mv_indx_q;
  assign in_tour = (state_q != IDLE);

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: the stimulus thread pushes expected
// commands/responses, a monitor thread pops and compares on each accept.
module tb_tour_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;
  logic        in_tour;

  logic        use_fixed;
  logic [7:0]  fixed_move;

  int checks;
  int errors;
  int tour_accepts;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];

  tour_cmd_seq #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .mv_indx          (mv_indx),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .resp             (resp),
    .in_tour          (in_tour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tour move store: mostly one-hot, a few multi-bit and zero entries.
  function automatic logic [7:0] tour_move(input int i);
    case (i)
      3:       return 8'h0C;
      9:       return 8'h00;
      14:      return 8'hA0;
      default: return 8'h01 << (i % 8);
    endcase
  endfunction

  // Bit that the sequencer must honour for tour entry i.
  function automatic int tour_bit(input int i);
    case (i)
      3:       return 2;
      9:       return 0;
      14:      return 5;
      default: return i % 8;
    endcase
  endfunction

  // Hand-computed vertical leg per move bit.
  function automatic logic [15:0] exp_v(input int b);
    case (b)
      0:       return 16'h4002;
      1:       return 16'h4002;
      2:       return 16'h4001;
      3:       return 16'h47F1;
      4:       return 16'h47F2;
      5:       return 16'h47F2;
      6:       return 16'h47F1;
      default: return 16'h4001;
    endcase
  endfunction

  // Hand-computed horizontal leg per move bit.
  function automatic logic [15:0] exp_h(input int b);
    case (b)
      0:       return 16'h53F1;
      1:       return 16'h5BF1;
      2:       return 16'h53F2;
      3:       return 16'h53F2;
      4:       return 16'h53F1;
      5:       return 16'h5BF1;
      6:       return 16'h5BF2;
      default: return 16'h5BF2;
    endcase
  endfunction

  assign move = use_fixed ? fixed_move : tour_move(int'(mv_indx));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every accepted command and every response.
  task automatic monitor();
    logic [15:0] ec;
    logic [7:0]  er;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_rdy && clr_cmd_rdy) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %h expected none at %0t", cmd, $time);
        end else begin
          ec = exp_cmd_q.pop_front();
          chk("cmd", cmd, ec);
        end
        if (in_tour) tour_accepts++;
      end
      if (rst_n && send_resp && in_tour) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got %h expected none at %0t", resp, $time);
        end else begin
          er = exp_resp_q.pop_front();
          chk("resp", 16'(resp), 16'(er));
        end
      end
      if (rst_n && in_tour && cmd_rdy_UART)
        chk("uart_ack_held", 16'(clr_cmd_rdy_UART), 16'd0);
    end
  endtask

  // Processor model for one leg: wait for cmd_rdy, accept, then respond.
  task automatic do_leg(input logic [15:0] ecmd, input logic [7:0] eresp);
    int n;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_rdy) begin
      checks++;
      errors++;
      $display("FAIL cmd_rdy_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    exp_cmd_q.push_back(ecmd);
    repeat ($urandom_range(0, 3)) tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_fall", 16'(cmd_rdy), 16'd0);
    repeat ($urandom_range(0, 3)) tick();
    exp_resp_q.push_back(eresp);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    chk("cmd_rdy_after_start", 16'(cmd_rdy), 16'd1);
    chk("mv_indx_after_start", 16'(mv_indx), 16'd0);
  endtask

  task automatic run_move(input int i, input bit last);
    chk("mv_indx_step", 16'(mv_indx), 16'(i));
    do_leg(exp_v(tour_bit(i)), 8'h5A);
    chk("cmd_rdy_rise_h", 16'(cmd_rdy), 16'd1);
    do_leg(exp_h(tour_bit(i)), last ? 8'hA5 : 8'h5A);
  endtask

  task automatic stimulus();
    logic [7:0] fixed_tbl[4];
    int         fixed_bit[4];
    int         base;
    fixed_tbl = '{8'h01, 8'h08, 8'h80, 8'h00};
    fixed_bit = '{0, 3, 7, 0};

    // Reset state and combinational pass-through while in reset.
    rst_n = 1'b0;
    #1;
    chk("rst_in_tour", 16'(in_tour), 16'd0);
    chk("rst_mv_indx", 16'(mv_indx), 16'd0);
    chk("rst_resp", 16'(resp), 16'h00A5);
    cmd_rdy_UART = 1'b1;
    #1;
    chk("rst_cmd_rdy_follow", 16'(cmd_rdy), 16'd1);
    cmd_rdy_UART = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // UART pass-through.
    cmd_UART     = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", cmd, 16'h2000);
    chk("uart_cmd_rdy", 16'(cmd_rdy), 16'd1);
    exp_cmd_q.push_back(16'h2000);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_ack", 16'(clr_cmd_rdy_UART), 16'd1);
    chk("uart_resp", 16'(resp), 16'h00A5);
    tick();
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    chk("uart_ack_drop", 16'(clr_cmd_rdy_UART), 16'd0);

    // Directed single moves, each aborted by reset after its two legs.
    use_fixed = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fixed_move = fixed_tbl[k];
      pulse_start();
      chk("first_leg_cmd", cmd, exp_v(fixed_bit[k]));
      do_leg(exp_v(fixed_bit[k]), 8'h5A);
      chk("cmd_rdy_rise_h", 16'(cmd_rdy), 16'd1);
      do_leg(exp_h(fixed_bit[k]), 8'h5A);
      chk("next_move_idx", 16'(mv_indx), 16'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    use_fixed = 1'b0;

    // Full tour with a UART command arriving at move 5.
    base = tour_accepts;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      if (i == 5) begin
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
      end
      run_move(i, i == 23);
    end
    chk("tour_accepts", 16'(tour_accepts - base), 16'd48);
    chk("end_in_tour", 16'(in_tour), 16'd0);
    chk("end_mv_indx", 16'(mv_indx), 16'd0);
    chk("uart_fwd_cmd", cmd, 16'h1234);
    chk("uart_fwd_rdy", 16'(cmd_rdy), 16'd1);
    exp_cmd_q.push_back(16'h1234);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_fwd_ack", 16'(clr_cmd_rdy_UART), 16'd1);
    tick();
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Abort by reset while in HORZ at move 10, then restart.
    pulse_start();
    for (int i = 0; i < 10; i++) run_move(i, 1'b0);
    chk("mv_indx_10", 16'(mv_indx), 16'd10);
    do_leg(exp_v(tour_bit(10)), 8'h5A);
    chk("horz_rdy", 16'(cmd_rdy), 16'd1);
    chk("horz_cmd", cmd, exp_h(tour_bit(10)));
    rst_n = 1'b0;
    #1;
    chk("abort_in_tour", 16'(in_tour), 16'd0);
    chk("abort_mv_indx", 16'(mv_indx), 16'd0);
    chk("abort_cmd_rdy", 16'(cmd_rdy), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    chk("restart_cmd", cmd, exp_v(tour_bit(0)));
    run_move(0, 1'b0);
    chk("restart_idx", 16'(mv_indx), 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("cmd_queue_empty", 16'(exp_cmd_q.size()), 16'd0);
    chk("resp_queue_empty", 16'(exp_resp_q.size()), 16'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    tour_accepts = 0;
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    use_fixed    = 1'b0;
    fixed_move   = 8'h00;
    fork
      stimulus();
      monitor();
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
